// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now, adder later).
package serial_arith_pkg;

   localparam int unsigned DefaultWidth = 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      StIdle = S_IDLE,
      StRun  = S_RUN,
      StDone = S_DONE
   } state_e;

endpackage

// File: rtl/full_subtractor_gatelevel_module.sv
// One-bit full subtractor built from primitive gates: diff = a ^ b ^ bin.
module full_subtractor_gatelevel_module (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   logic a_xor_b;
   logic a_n;
   logic a_xnor_b;
   logic gen_borrow;
   logic prop_borrow;

   xor g_xor_ab   (a_xor_b, a, b);
   xor g_xor_diff (diff, a_xor_b, bin);
   not g_not_a    (a_n, a);
   not g_not_x    (a_xnor_b, a_xor_b);
   and g_and_gen  (gen_borrow, a_n, b);
   and g_and_prop (prop_borrow, a_xnor_b, bin);
   or  g_or_bout  (bout, gen_borrow, prop_borrow);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock with a registered borrow.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_r_q;
   logic             borrow_out_q;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             bit_d;
   logic             bit_bout;

   full_subtractor_gatelevel_module u_full_sub (
      .a    (sa_q[0]),
      .b    (sb_q[0]),
      .bin  (borrow_r_q),
      .diff (bit_d),
      .bout (bit_bout)
   );

   always_comb begin
      sa_d  = sa_q >> 1;
      sb_d  = sb_q >> 1;
      res_d = {bit_d, res_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
   end

   // diff/borrow outputs are separate from the working result so they only move entering DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         sa_q         <= '0;
         sb_q         <= '0;
         res_q        <= '0;
         diff_q       <= '0;
         borrow_r_q   <= 1'b0;
         borrow_out_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  sa_q       <= a;
                  sb_q       <= b;
                  borrow_r_q <= 1'b0;
                  cnt_q      <= '0;
                  state_q    <= StRun;
               end
            end
            StRun: begin
               sa_q       <= sa_d;
               sb_q       <= sb_d;
               res_q      <= res_d;
               borrow_r_q <= bit_bout;
               cnt_q      <= cnt_d;
               if (cnt_q == LastBit) begin
                  diff_q       <= res_d;
                  borrow_out_q <= bit_bout;
                  state_q      <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
      diff      = diff_q;
      borrow    = borrow_out_q;
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8) against an arithmetic a - b model.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         borrow;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
      int unsigned r;
      r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
      return W'(r);
   endfunction

   function automatic logic model_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
      return int'(x) < int'(y);
   endfunction

   // Drives one operation from IDLE with out_ready=1; lat = edges from accept to out_valid.
   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output logic [W-1:0] od, output logic ob, output int lat);
      @(negedge clk);
      a = ia;
      b = ib;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      od = diff;
      ob = borrow;
      @(posedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0) begin
         errors++;
         $display("FAIL reset: in_ready=%b out_valid=%b diff=%h borrow=%b, required 1 0 00 0",
                  in_ready, out_valid, diff, borrow);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [5] = '{8'h5A, 8'h10, 8'h00, 8'hFF, 8'hFF};
      logic [W-1:0] tb [5] = '{8'h23, 8'h20, 8'h01, 8'hFF, 8'h00};
      logic [W-1:0] td [5] = '{8'h37, 8'hF0, 8'hFF, 8'h00, 8'hFF};
      logic         tbr[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [W-1:0] gd;
      logic         gb;
      int           lat;
      for (int i = 0; i < 5; i++) begin
         do_op(ta[i], tb[i], gd, gb, lat);
         checks++;
         if (gd !== td[i] || gb !== tbr[i]) begin
            errors++;
            $display("FAIL directed_%0d: %h-%h got diff=%h borrow=%b, required %h %b",
                     i, ta[i], tb[i], gd, gb, td[i], tbr[i]);
         end
         checks++;
         if (lat != W) begin
            errors++;
            $display("FAIL latency_%0d: got %0d cycles, required %0d", i, lat, W);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] hd;
      logic         hb;
      int           n;
      @(negedge clk);
      a = 8'h33;
      b = 8'h11;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      // new operands mid-RUN must be ignored
      a = 8'hAA;
      b = 8'h01;
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL busy_in_ready: got %b, required 0", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      hd = diff;
      hb = borrow;
      checks++;
      if (hd !== model_diff(8'h33, 8'h11) || hb !== model_borrow(8'h33, 8'h11)) begin
         errors++;
         $display("FAIL busy_ignore: got diff=%h borrow=%b, required %h %b",
                  hd, hb, model_diff(8'h33, 8'h11), model_borrow(8'h33, 8'h11));
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== hd || borrow !== hb) begin
            errors++;
            $display("FAIL hold_%0d: out_valid=%b in_ready=%b diff=%h borrow=%b, required 1 0 %h %b",
                     i, out_valid, in_ready, diff, borrow, hd, hb);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] gd;
      logic         gb;
      int           lat;
      int           seen;
      @(negedge clk);
      a = 8'h44;
      b = 8'h11;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid_run: in_ready=%b out_valid=%b diff=%h, required 1 0 00",
                  in_ready, out_valid, diff);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL discarded_op: got %0d out_valid cycles, required 0", seen);
      end
      do_op(8'h80, 8'h01, gd, gb, lat);
      checks++;
      if (gd !== 8'h7F || gb !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_op: got diff=%h borrow=%b, required 7f 0", gd, gb);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] oa[3] = '{8'h9C, 8'h01, 8'h7E};
      logic [W-1:0] ob[3] = '{8'h3D, 8'hF0, 8'h7E};
      int           acc_cyc[3] = '{0, 0, 0};
      logic [W-1:0] rd[$];
      logic         rb[$];
      int           idx = 0;
      int           cyc = 0;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      while (rd.size() < 3 && cyc < 100) begin
         if (in_ready) begin
            if (idx < 3) begin
               a = oa[idx];
               b = ob[idx];
               acc_cyc[idx] = cyc;
               idx++;
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            rd.push_back(diff);
            rb.push_back(borrow);
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (rd.size() != 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d results, required 3", rd.size());
      end
      for (int i = 0; i < 3 && i < rd.size(); i++) begin
         checks++;
         if (rd[i] !== model_diff(oa[i], ob[i]) || rb[i] !== model_borrow(oa[i], ob[i])) begin
            errors++;
            $display("FAIL b2b_result_%0d: got diff=%h borrow=%b, required %h %b", i, rd[i], rb[i],
                     model_diff(oa[i], ob[i]), model_borrow(oa[i], ob[i]));
         end
      end
      for (int i = 1; i < 3; i++) begin
         checks++;
         if (acc_cyc[i] - acc_cyc[i-1] != W + 2) begin
            errors++;
            $display("FAIL b2b_spacing_%0d: got %0d cycles, required %0d",
                     i, acc_cyc[i] - acc_cyc[i-1], W + 2);
         end
      end
   endtask

   task automatic test_random_sweep();
      logic [W-1:0] ra, rb_, gd;
      logic         gb;
      int           lat;
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom);
         rb_ = W'($urandom);
         do_op(ra, rb_, gd, gb, lat);
         checks++;
         if (gd !== model_diff(ra, rb_) || gb !== model_borrow(ra, rb_) || lat != W) begin
            errors++;
            $display("FAIL random_%0d: %h-%h got diff=%h borrow=%b lat=%0d, required %h %b %0d",
                     i, ra, rb_, gd, gb, lat, model_diff(ra, rb_), model_borrow(ra, rb_), W);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      test_random_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
